var1_sweep: RTL and testbench
=============================

# var1_sweep

Self-checking stimulus sequencer placed directly upstream of the 5-input combinational function stage. On `start` it drives every 5-bit input vector, 0 to 31, into that stage. It holds each vector for a programmable settle time and samples the stage's 1-bit result into a 32-bit truth table. It compares each sample against a golden table and reports a mismatch count and a pass flag, so the function can be verified on hardware with one button and a few LEDs.

## Interface
- `SETTLE`, default 2: cycles each vector is held before sampling; legal range 1..15.
- `EXPECTED`, default 32'hF1F1F10E: golden truth table; bit i is the expected result for input vector i.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: level-sampled sweep request; acted on only in IDLE.
- `dut_out` in 1: result from the function stage for the vector currently on `dut_in`.
- `dut_in` out 5: vector driven to the function stage; registered.
- `busy` out 1: high while a sweep is in progress.
- `done` out 1: one-cycle pulse when a sweep completes.
- `table` out 32: captured results; bit i is the sample taken for vector i.
- `mismatch_cnt` out 6: number of vectors where the captured bit differs from the `EXPECTED` bit; range 0..32.
- `pass` out 1: high when the last completed sweep had `mismatch_cnt` = 0.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `busy` = 0.
  - If `start` = 1, go to RUN. In the same edge: `dut_in` <= 0, settle counter <= 0, `table` <= 0, `mismatch_cnt` <= 0, `pass` <= 0.
- RUN:
  - `busy` = 1.
  - Settle counter (4-bit) increments each cycle.
  - When the counter equals SETTLE-1:
    - `table[dut_in]` <= `dut_out`.
    - If `dut_out` != `EXPECTED[dut_in]`, `mismatch_cnt` increments.
    - Counter resets to 0.
    - If `dut_in` = 31, go to DONE and leave `dut_in` at 31. Otherwise `dut_in` increments.
- DONE:
  - Lasts exactly one cycle. `done` = 1 and `busy` = 0.
  - `pass` <= (`mismatch_cnt` = 0).
  - Return to IDLE.
- `start` is ignored in RUN and in DONE; it must be re-asserted in IDLE.
- `start` held high continuously restarts a sweep on each IDLE visit, one cycle after DONE.
- `table`, `mismatch_cnt`, `pass` and `dut_in` hold their values in IDLE until the next accepted `start`.
- Width rules:
  - `dut_in` never wraps; 31 is terminal.
  - `mismatch_cnt` saturation is impossible, because 6 bits cover 32.
  - `table` is indexed by `dut_in` directly.
- Reset (`rst_n` = 0 at a rising edge) applies in any state, including mid-RUN:
  - State goes to IDLE.
  - `dut_in` = 0, `busy` = 0, `done` = 0, `table` = 0, `mismatch_cnt` = 0, `pass` = 0, settle counter = 0.
  - The partial sweep is discarded and `done` is not pulsed.
  - Reset has priority over `start`.

## Timing
- Vector k is driven for exactly SETTLE cycles.
- `dut_out` is sampled on the rising edge that ends the last of those cycles. This gives SETTLE-1 full cycles of margin for the combinational stage plus routing.
- Start-to-done latency:
  - Edge E accepts `start`.
  - `busy` = 1 from E to E+32·SETTLE.
  - `done` is high in the cycle after edge E+32·SETTLE.
  - For SETTLE = 2, `done` is high 64 cycles after acceptance.
- In the `done` cycle, `table` and `mismatch_cnt` are final.
- `pass` updates on the edge that ends the `done` cycle.
- `done` and `busy` are never high together.
- `dut_in` changes only on sample edges or at sweep start.

## Test plan
- Reset values: assert `rst_n` = 0 for 2 cycles with `start` = 1 → `dut_in` = 0, `busy` = 0, `done` = 0, `table` = 0, `mismatch_cnt` = 0, `pass` = 0. No sweep starts during reset.
- Golden sweep: SETTLE = 2, bench models `dut_out = (in[4]|in[3]) ^ (~in[2] & (in[1]|in[0]))`, pulse `start` → `done` 64 cycles after acceptance, `table` = 32'hF1F1F10E, `mismatch_cnt` = 0, `pass` = 1. Check that each `dut_in` value is stable for exactly 2 cycles.
- Fault injection: same as the golden sweep, but invert `dut_out` only while `dut_in` = 5 → `table` = 32'hF1F1F12E, `mismatch_cnt` = 1, `pass` = 0.
- Stuck-at-0: `dut_out` = 0 throughout → `table` = 0, `mismatch_cnt` = 18, `pass` = 0.
- Control boundaries:
  - Pulse `start` while `dut_in` = 12 in RUN → no restart, and the sweep completes normally.
  - Hold `start` high → a second sweep begins one cycle after `done`, with results cleared on acceptance.
- Reset mid-sweep: assert `rst_n` = 0 when `dut_in` = 10 → next cycle all outputs are at reset values and no `done` pulse occurs. A fresh `start` then produces a full 64-cycle sweep.
- SETTLE = 1 build: golden sweep → `done` 32 cycles after acceptance and `table` = 32'hF1F1F10E.

Source files
------------

// File: rtl/var1_sweep.sv
// Truth-table sweeper: drives vectors 0..31 into a 5-input function stage,
// samples each result after SETTLE cycles and grades it against EXPECTED.
// Ports: clk, rst_n (sync, active-low), start, dut_out -> dut_in, busy,
//   done, result_table (bit i = sample for vector i), mismatch_cnt, pass.
module var1_sweep #(
  parameter int unsigned SETTLE   = 2,
  parameter logic [31:0] EXPECTED = 32'hF1F1F10E
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        dut_out,
  output logic [4:0]  dut_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result_table,
  output logic [5:0]  mismatch_cnt,
  output logic        pass
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] LAST = 4'(SETTLE - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  in_q, in_d;
  logic [31:0] tbl_q, tbl_d;
  logic [5:0]  mis_q, mis_d;
  logic        pass_q, pass_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    in_d    = in_q;
    tbl_d   = tbl_q;
    mis_d   = mis_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          in_d    = '0;
          tbl_d   = '0;
          mis_d   = '0;
          pass_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (cnt_q == LAST) begin
          cnt_d        = '0;
          tbl_d[in_q]  = dut_out;
          if (dut_out != EXPECTED[in_q])
            mis_d = mis_q + 6'd1;
          // Vector 31 is terminal: hold it rather than wrap.
          if (in_q == 5'd31)
            state_d = S_DONE;
          else
            in_d = in_q + 5'd1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        pass_d  = (mis_q == 6'd0);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      in_q    <= '0;
      tbl_q   <= '0;
      mis_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      in_q    <= in_d;
      tbl_q   <= tbl_d;
      mis_q   <= mis_d;
      pass_q  <= pass_d;
    end
  end

  assign dut_in       = in_q;
  assign busy         = (state_q == S_RUN);
  assign done         = (state_q == S_DONE);
  assign result_table = tbl_q;
  assign mismatch_cnt = mis_q;
  assign pass         = pass_q;

endmodule

// File: tb/tb_var1_sweep.sv
// Scoreboard bench for var1_sweep: random fault masks on the function
// stage, expected tables from a behavioural model, checked on done.
module tb_var1_sweep;

  logic        clk = 1'b0;
  logic        rst_n, start, dut_out;
  logic [4:0]  dut_in;
  logic        busy, done, pass;
  logic [31:0] tbl;
  logic [5:0]  mis;

  logic        start1, dut_out1;
  logic [4:0]  dut_in1;
  logic        busy1, done1, pass1;
  logic [31:0] tbl1;
  logic [5:0]  mis1;

  logic [31:0] mask;
  logic        stuck;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] tbl;
    logic [5:0]  mis;
    logic        pass;
  } exp_t;

  exp_t expq[$];

  always #5 clk = ~clk;

  var1_sweep #(.SETTLE(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_out(dut_out),
    .dut_in(dut_in), .busy(busy), .done(done), .result_table(tbl),
    .mismatch_cnt(mis), .pass(pass)
  );

  var1_sweep #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .dut_out(dut_out1),
    .dut_in(dut_in1), .busy(busy1), .done(done1), .result_table(tbl1),
    .mismatch_cnt(mis1), .pass(pass1)
  );

  function automatic logic gold(input logic [4:0] v);
    return (v[4] | v[3]) ^ (~v[2] & (v[1] | v[0]));
  endfunction

  function automatic exp_t model(input logic [31:0] m, input logic s);
    exp_t e;
    logic [31:0] g;
    for (int i = 0; i < 32; i++) begin
      g[i]     = gold(5'(i));
      e.tbl[i] = s ? 1'b0 : (g[i] ^ m[i]);
    end
    e.mis  = 6'($countones(e.tbl ^ g));
    e.pass = (e.mis == 6'd0);
    return e;
  endfunction

  assign dut_out  = stuck ? 1'b0 : (gold(dut_in) ^ mask[dut_in]);
  assign dut_out1 = gold(dut_in1);

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor
  int         busy_cyc = 0;
  int         hold = 0;
  logic       busy_prev = 1'b0;
  logic [4:0] in_prev = '0;
  logic       pass_pending = 1'b0;
  exp_t       pend;

  always @(negedge clk) begin
    if (pass_pending) begin
      chk("pass", 32'(pass), 32'(pend.pass));
      pass_pending = 1'b0;
    end
    if (busy && done) chk("busy_done_overlap", 32'(busy & done), 32'd0);
    if (busy && !busy_prev) begin
      busy_cyc = 0;
      hold     = 0;
      in_prev  = dut_in;
      chk("clear_table", tbl, 32'd0);
      chk("clear_mis", 32'(mis), 32'd0);
      chk("clear_pass", 32'(pass), 32'd0);
      chk("first_vec", 32'(dut_in), 32'd0);
    end
    if (busy) begin
      busy_cyc++;
      if (dut_in == in_prev) begin
        hold++;
      end else begin
        chk("hold_len", 32'(hold), 32'd2);
        chk("vec_step", 32'(dut_in), 32'(in_prev + 5'd1));
        hold    = 1;
        in_prev = dut_in;
      end
    end
    if (done) begin
      chk("hold_last", 32'(hold), 32'd2);
      chk("latency", 32'(busy_cyc), 32'd64);
      chk("final_vec", 32'(dut_in), 32'd31);
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected none");
      end else begin
        pend = expq.pop_front();
        chk("table", tbl, pend.tbl);
        chk("mismatch_cnt", 32'(mis), 32'(pend.mis));
        pass_pending = 1'b1;
      end
    end
    busy_prev = busy;
  end

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done");
    end
    @(negedge clk);
  endtask

  task automatic wait_vec(input logic [4:0] v);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (busy && dut_in == v) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL vec_timeout: got no dut_in=%0d expected it", v);
    end
  endtask

  task automatic run_sweep(input logic [31:0] m, input logic s);
    mask  = m;
    stuck = s;
    expq.push_back(model(m, s));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dut_in"}, 32'(dut_in), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_table"}, tbl, 32'd0);
    chk({tag, "_mis"}, 32'(mis), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd0);
  endtask

  initial begin
    int cnt1;
    bit seen1;
    rst_n  = 1'b0;
    start  = 1'b1;
    start1 = 1'b1;
    mask   = '0;
    stuck  = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    chk("reset_busy1", 32'(busy1), 32'd0);
    start  = 1'b0;
    start1 = 1'b0;
    rst_n  = 1'b1;
    @(negedge clk);

    run_sweep(32'd0, 1'b0);
    run_sweep(32'h0000_0020, 1'b0);
    run_sweep(32'd0, 1'b1);

    // start pulse mid-run must be ignored
    mask  = $urandom;
    stuck = 1'b0;
    expq.push_back(model(mask, stuck));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_vec(5'd12);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // start held: back-to-back sweeps, one IDLE cycle between
    stuck = 1'b1;
    mask  = '0;
    expq.push_back(model(mask, stuck));
    expq.push_back(model(mask, stuck));
    start = 1'b1;
    begin
      bit seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
        @(negedge clk);
        if (done) seen = 1;
      end
      if (!seen) begin
        checks++;
        errors++;
        $display("FAIL held_timeout: got no done expected done");
      end
    end
    @(negedge clk);
    chk("gap_idle", 32'(busy), 32'd0);
    @(negedge clk);
    chk("restart", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done();

    // reset mid-sweep: discard, no done
    mask  = $urandom;
    stuck = 1'b0;
    expq.push_back(model(mask, stuck));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_vec(5'd10);
    rst_n = 1'b0;
    start = 1'b1;
    @(negedge clk);
    chk_reset_vals("midreset");
    expq.delete();
    rst_n = 1'b0;
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    chk("no_done_after_reset", 32'(busy), 32'd0);
    run_sweep(32'd0, 1'b0);

    repeat (4) run_sweep($urandom, ($urandom_range(0, 3) == 0));

    // SETTLE = 1 instance
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    cnt1  = busy1 ? 1 : 0;
    seen1 = 0;
    for (int i = 0; i < 100 && !seen1; i++) begin
      @(negedge clk);
      if (done1) seen1 = 1;
      else if (busy1) cnt1++;
    end
    if (!seen1) begin
      checks++;
      errors++;
      $display("FAIL s1_timeout: got no done1 expected done1");
    end
    chk("s1_latency", 32'(cnt1), 32'd32);
    chk("s1_table", tbl1, model(32'd0, 1'b0).tbl);
    chk("s1_mis", 32'(mis1), 32'd0);
    @(negedge clk);
    chk("s1_pass", 32'(pass1), 32'd1);

    @(negedge clk);
    chk("queue_empty", 32'(expq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
